// File: rtl/keccak_pkg.sv
// ----------------------------------------------------------------------------
// keccak_pkg
// Shared Keccak definitions for the theta engine and the later chi/rho blocks.
//   ROWS/COLS/PLANE_W : geometry of one 5x5 slice (bit 5*y+x = A[x,y])
//   plane_t / col_t   : one slice / one row of column parities
//   state_t           : theta engine sequencer states
//   idx(x,y)          : bit index of A[x,y] within a slice
//   column_parity()   : C[x] = XOR of A[x,0..4]
// ----------------------------------------------------------------------------
package keccak_pkg;

    localparam int ROWS    = 5;
    localparam int COLS    = 5;
    localparam int PLANE_W = ROWS * COLS;

    typedef logic [PLANE_W-1:0] plane_t;
    typedef logic [COLS-1:0]    col_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        SWEEP,
        DRAIN
    } state_t;

    function automatic int idx(input int x, input int y);
        return COLS * y + x;
    endfunction

    // Rows are 5-bit fields, so XOR-ing the five rows yields every column at once.
    function automatic col_t column_parity(input plane_t s);
        return s[4:0] ^ s[9:5] ^ s[14:10] ^ s[19:15] ^ s[24:20];
    endfunction

endpackage

// File: rtl/theta_column_engine_if.sv
// ----------------------------------------------------------------------------
// theta_column_engine_if
// Slice-RAM read port plus the valid/ready output stream of the theta engine.
//   rd_en, rd_addr   : read request (engine -> RAM), data returns next cycle
//   rd_data          : slice read back (RAM -> engine)
//   out_valid/ready  : output handshake
//   out_data/addr    : processed slice and its index
//   out_parity       : column parity of out_data (only with THETA_PARITY_OUT_EN)
// Modports: master = engine side, slave = RAM/consumer side.
// ----------------------------------------------------------------------------
interface theta_column_engine_if #(
    parameter int SLICES = 64,
    parameter int IDX_W  = $clog2(SLICES)
) ();
    import keccak_pkg::*;

    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    plane_t           rd_data;
    logic             out_valid;
    logic             out_ready;
    plane_t           out_data;
    logic [IDX_W-1:0] out_addr;
`ifdef THETA_PARITY_OUT_EN
    col_t             out_parity;

    modport master (output rd_en, rd_addr, out_valid, out_data, out_addr, out_parity,
                    input  rd_data, out_ready);
    modport slave  (input  rd_en, rd_addr, out_valid, out_data, out_addr, out_parity,
                    output rd_data, out_ready);
`else
    modport master (output rd_en, rd_addr, out_valid, out_data, out_addr,
                    input  rd_data, out_ready);
    modport slave  (input  rd_en, rd_addr, out_valid, out_data, out_addr,
                    output rd_data, out_ready);
`endif

endinterface

// File: rtl/theta_slice_xor.sv
// ----------------------------------------------------------------------------
// theta_slice_xor
// Combinational theta of one slice given the previous slice's column parity.
//   slice     in  25  A[x,y] of slice z
//   cprev     in   5  column parity of slice z-1
//   theta_en  in   1  0 = pass slice through unchanged
//   out_slice out 25  A[x,y] ^ D[x], D[x] = C[x-1] ^ cprev[x+1] (mod 5)
//   col_par   out  5  column parity C of the input slice
// ----------------------------------------------------------------------------
module theta_slice_xor
    import keccak_pkg::*;
(
    input  plane_t slice,
    input  col_t   cprev,
    input  logic   theta_en,
    output plane_t out_slice,
    output col_t   col_par
);

    col_t d;

    always_comb begin
        // NOTE: every output gets a value before any condition, so no latch is inferred.
        col_par   = column_parity(slice);
        // Rotate left gives C[x-1]; rotate right gives cprev[x+1].
        d         = {col_par[3:0], col_par[4]} ^ {cprev[0], cprev[4:1]};
        out_slice = slice;
        if (theta_en) begin
            out_slice = slice ^ {ROWS{d}};
        end
    end

endmodule

// File: rtl/theta_column_engine.sv
// ----------------------------------------------------------------------------
// theta_column_engine
// Streams slices 0..SLICES-1 from slice RAM, applies Keccak theta (or bypass)
// and emits them through a 2-entry output FIFO with valid/ready backpressure.
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low
//   start     in   one-cycle pulse, accepted only in IDLE
//   theta_en  in   latched at start; 0 = bypass
//   busy      out  high while an operation is in progress
//   done      out  one-cycle pulse after the last output handshake
//   bus       master side of theta_column_engine_if (RAM read + output stream)
// Optional feature macro: THETA_PARITY_OUT_EN adds bus.out_parity, the column
// parity of out_data, stored in the FIFO (0 in bypass).
// ----------------------------------------------------------------------------
module theta_column_engine
    import keccak_pkg::*;
#(
    parameter int SLICES = 64,
    parameter int IDX_W  = $clog2(SLICES)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic theta_en,
    output logic busy,
    output logic done,
    theta_column_engine_if.master bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(SLICES - 1);

    state_t           state;
    logic             theta_q;
    logic             prime_q;       // wrap slice is on rd_data this cycle
    logic             data_q;        // a sweep slice is on rd_data this cycle
    logic [IDX_W-1:0] addr_q;
    logic [IDX_W-1:0] data_addr_q;
    col_t             cprev;
    col_t             slice_c;
    plane_t           xor_out;

    plane_t           fifo_data [2];
    logic [IDX_W-1:0] fifo_addr [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       occ_next;
    logic             push;
    logic             pop;
    logic             issue;

    theta_slice_xor u_xor (
        .slice     (bus.rd_data),
        .cprev     (cprev),
        .theta_en  (theta_q),
        .out_slice (xor_out),
        .col_par   (slice_c)
    );

    assign push     = data_q;
    assign pop      = bus.out_valid & bus.out_ready;
    assign occ_next = count + {1'b0, push} - {1'b0, pop};

    // A new read lands in the FIFO two edges from now; allowing it only while
    // post-edge occupancy plus the read already returning stays below two keeps
    // the FIFO from overflowing yet still sustains one slice per clock. The
    // request is decoded combinationally so this cycle's pop can be credited.
    assign issue       = (state == SWEEP) && (occ_next < 2'd2);
    assign bus.rd_en   = (state == PRIME) || issue;
    assign bus.rd_addr = addr_q;

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = fifo_data[rd_ptr];
    assign bus.out_addr  = fifo_addr[rd_ptr];

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            theta_q     <= 1'b0;
            prime_q     <= 1'b0;
            data_q      <= 1'b0;
            addr_q      <= '0;
            data_addr_q <= '0;
            cprev       <= '0;
        end else begin
            done    <= 1'b0;
            prime_q <= 1'b0;
            data_q  <= 1'b0;
            // The wrap slice and every processed slice both leave their parity behind.
            if (prime_q || data_q) begin
                cprev <= slice_c;
            end
            case (state)
                IDLE: begin
                    // A start coinciding with done is dropped; it is taken a cycle later.
                    if (start && !done) begin
                        theta_q <= theta_en;
                        busy    <= 1'b1;
                        addr_q  <= LAST;
                        state   <= PRIME;
                    end
                end
                PRIME: begin
                    prime_q <= 1'b1;
                    addr_q  <= '0;
                    state   <= SWEEP;
                end
                SWEEP: begin
                    if (issue) begin
                        data_q      <= 1'b1;
                        data_addr_q <= addr_q;
                        if (addr_q == LAST) begin
                            state <= DRAIN;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (occ_next == 2'd0) begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        addr_q <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the two FIFO entries are reset so out_data reads zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_addr[0] <= '0;
            fifo_addr[1] <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= xor_out;
                fifo_addr[wr_ptr] <= data_addr_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= occ_next;
        end
    end

`ifdef THETA_PARITY_OUT_EN
    col_t fifo_par [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_par[0] <= '0;
            fifo_par[1] <= '0;
        end else if (push) begin
            fifo_par[wr_ptr] <= theta_q ? column_parity(xor_out) : '0;
        end
    end

    assign bus.out_parity = fifo_par[rd_ptr];
`endif

endmodule

// File: tb/tb_theta_column_engine.sv
// ----------------------------------------------------------------------------
// tb_theta_column_engine
// Directed bench for theta_column_engine: a 64-slice instance and an 8-slice
// instance share clk/reset, each with a one-cycle-latency slice RAM model and
// a negedge monitor that records every output handshake.
// ----------------------------------------------------------------------------
module tb_theta_column_engine;
    import keccak_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   tests = 0;
    int   fails = 0;
    logic clr   = 1'b0;
    int   bad;
    int   dup;
    int   t64;
    int   t8;

    // ---------------- 64-slice instance ----------------
    logic   start64 = 1'b0;
    logic   ten64   = 1'b1;
    logic   busy64;
    logic   done64;
    plane_t mem64 [64];

    theta_column_engine_if #(.SLICES(64)) bus64 ();

    theta_column_engine #(.SLICES(64)) u64 (
        .clk      (clk),
        .reset    (reset),
        .start    (start64),
        .theta_en (ten64),
        .busy     (busy64),
        .done     (done64),
        .bus      (bus64)
    );

    always @(posedge clk) if (bus64.rd_en) bus64.rd_data <= mem64[bus64.rd_addr];

    plane_t     got64 [64];
    int         cnt64 [64];
    int         n64 = 0, dn64 = 0, dcyc64 = -1, fv64 = -1, ord64 = 0, stall64 = 0, last64 = -1;
    logic       stalled64 = 1'b0;
    plane_t     sd64;
    logic [5:0] sa64;

    always @(negedge clk) begin
        if (clr) begin
            n64 = 0; dn64 = 0; dcyc64 = -1; fv64 = -1; ord64 = 0; stall64 = 0; last64 = -1;
            stalled64 = 1'b0;
            for (int i = 0; i < 64; i++) begin
                got64[i] = '0;
                cnt64[i] = 0;
            end
        end else begin
            if (stalled64 && (!bus64.out_valid || bus64.out_data !== sd64 || bus64.out_addr !== sa64))
                stall64++;
            stalled64 = bus64.out_valid && !bus64.out_ready;
            sd64      = bus64.out_data;
            sa64      = bus64.out_addr;
            if (bus64.out_valid && fv64 < 0) fv64 = cyc;
            if (bus64.out_valid && bus64.out_ready) begin
                if (int'(bus64.out_addr) != last64 + 1) ord64++;
                last64 = int'(bus64.out_addr);
                got64[bus64.out_addr] = bus64.out_data;
                cnt64[bus64.out_addr]++;
                n64++;
            end
            if (done64) begin
                dn64++;
                dcyc64 = cyc;
            end
        end
    end

    // ---------------- 8-slice instance ----------------
    logic   start8 = 1'b0;
    logic   busy8;
    logic   done8;
    plane_t mem8 [8];

    theta_column_engine_if #(.SLICES(8)) bus8 ();

    theta_column_engine #(.SLICES(8)) u8 (
        .clk      (clk),
        .reset    (reset),
        .start    (start8),
        .theta_en (1'b1),
        .busy     (busy8),
        .done     (done8),
        .bus      (bus8)
    );

    always @(posedge clk) if (bus8.rd_en) bus8.rd_data <= mem8[bus8.rd_addr];

    plane_t got8 [8];
    int     n8 = 0, dn8 = 0, dcyc8 = -1;

    always @(negedge clk) begin
        if (clr) begin
            n8 = 0; dn8 = 0; dcyc8 = -1;
            for (int i = 0; i < 8; i++) got8[i] = '0;
        end else begin
            if (bus8.out_valid && bus8.out_ready) begin
                got8[bus8.out_addr] = bus8.out_data;
                n8++;
            end
            if (done8) begin
                dn8++;
                dcyc8 = cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic par(input plane_t s, input int x);
        return s[idx(x, 0)] ^ s[idx(x, 1)] ^ s[idx(x, 2)] ^ s[idx(x, 3)] ^ s[idx(x, 4)];
    endfunction

    // Reference theta of page z over the whole 64-page state.
    function automatic plane_t ref64(input int z);
        plane_t a = mem64[z];
        plane_t p = mem64[(z + 63) % 64];
        plane_t r = a;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[idx(x, y)] = a[idx(x, y)] ^ par(a, (x + 4) % 5) ^ par(p, (x + 1) % 5);
        return r;
    endfunction

    task automatic clear_mon();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic start64_pulse(input logic te);
        @(posedge clk); #1;
        ten64   = te;
        start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        t64     = cyc;
    endtask

    task automatic wait_done64(input int budget, input string tag);
        for (int i = 0; i < budget && dn64 == 0; i++) @(posedge clk);
        check(tag, (dn64 != 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus64.out_ready = 1'b1;
        bus8.out_ready  = 1'b1;
        for (int z = 0; z < 64; z++) mem64[z] = '0;
        for (int z = 0; z < 8; z++)  mem8[z]  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      busy64,          0);
        check("rst_done",      done64,          0);
        check("rst_rd_en",     bus64.rd_en,     0);
        check("rst_rd_addr",   bus64.rd_addr,   0);
        check("rst_out_valid", bus64.out_valid, 0);
        check("rst_out_data",  bus64.out_data,  0);
        check("rst_out_addr",  bus64.out_addr,  0);
        reset = 1'b1;

        // 1. All-zero state, out_ready held high
        clear_mon();
        start64_pulse(1'b1);
        check("t1_busy",       busy64,        1);
        check("t1_prime_en",   bus64.rd_en,   1);
        check("t1_prime_addr", bus64.rd_addr, 63);
        wait_done64(200, "t1_done_seen");
        bad = 0; dup = 0;
        for (int z = 0; z < 64; z++) begin
            if (got64[z] !== '0) bad++;
            if (cnt64[z] != 1) dup++;
        end
        check("t1_outputs",    n64,          64);
        check("t1_nonzero",    bad,          0);
        check("t1_dup_lost",   dup,          0);
        check("t1_order",      ord64,        0);
        check("t1_done_count", dn64,         1);
        check("t1_start_done", dcyc64 - t64, 67);
        check("t1_first_vld",  fv64 - t64,   3);
        check("t1_busy_after", busy64,       0);

        // 2. Single bit in page 0
        mem64[0] = 25'h0000001;
        clear_mon();
        start64_pulse(1'b1);
        wait_done64(200, "t2_done_seen");
        bad = 0;
        for (int z = 2; z < 64; z++) if (got64[z] !== '0) bad++;
        check("t2_page0", got64[0], 32'h0210843);
        check("t2_page1", got64[1], 32'h1084210);
        check("t2_other", bad,      0);

        // 3. Single bit in page 63: parity must wrap into page 0
        mem64[0]  = '0;
        mem64[63] = 25'h0000001;
        clear_mon();
        start64_pulse(1'b1);
        wait_done64(200, "t3_done_seen");
        bad = 0;
        for (int z = 1; z < 63; z++) if (got64[z] !== '0) bad++;
        check("t3_page0",  got64[0],  32'h1084210);
        check("t3_page63", got64[63], 32'h0210843);
        check("t3_other",  bad,       0);

        // 4. Random state with out_ready 1010..., then 10 clocks stalled
        for (int z = 0; z < 64; z++) mem64[z] = plane_t'($urandom);
        clear_mon();
        start64_pulse(1'b1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 bus64.out_ready = (i % 2 == 0);
        end
        @(posedge clk); #1 bus64.out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus64.out_ready = 1'b1;
        wait_done64(400, "t4_done_seen");
        bad = 0; dup = 0;
        for (int z = 0; z < 64; z++) begin
            if (got64[z] !== ref64(z)) bad++;
            if (cnt64[z] != 1) dup++;
        end
        check("t4_outputs",   n64,     64);
        check("t4_model",     bad,     0);
        check("t4_dup_lost",  dup,     0);
        check("t4_order",     ord64,   0);
        check("t4_stall_hold", stall64, 0);
        check("t4_done_count", dn64,    1);

        // 5. Bypass with reset asserted at the 20th output
        for (int z = 0; z < 64; z++) mem64[z] = plane_t'($urandom);
        clear_mon();
        start64_pulse(1'b0);
        for (int i = 0; i < 200 && n64 < 20; i++) begin
            @(negedge clk); #1;
        end
        check("t5_reached20", n64, 20);
        reset = 1'b0;
        #1;
        bad = 0;
        for (int z = 0; z < 20; z++) if (got64[z] !== mem64[z]) bad++;
        check("t5_bypass_data", bad,             0);
        check("t5_rst_busy",    busy64,          0);
        check("t5_rst_valid",   bus64.out_valid, 0);
        check("t5_rst_data",    bus64.out_data,  0);
        check("t5_rst_addr",    bus64.out_addr,  0);
        check("t5_rst_rd_en",   bus64.rd_en,     0);
        check("t5_rst_rd_addr", bus64.rd_addr,   0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_done", dn64,   0);
        check("t5_idle",    busy64, 0);

        // 6. SLICES=8: A[4,4] in page 7, second start while busy is ignored
        mem8[7] = 25'h1000000;
        clear_mon();
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        t8 = cyc;
        check("t6_prime_addr", bus8.rd_addr, 7);
        repeat (3) @(posedge clk);
        #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        for (int i = 0; i < 100 && dn8 == 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        bad = 0;
        for (int z = 1; z < 7; z++) if (got8[z] !== '0) bad++;
        // page7: D[0]=C[4]=1 -> bits 0,5,10,15,20 = 0x0108421, XOR input bit 24
        check("t6_page7",      got8[7],     32'h1108421);
        // page0: D[3]=cprev[4]=1 -> bits 3,8,13,18,23
        check("t6_page0",      got8[0],     32'h0842108);
        check("t6_other",      bad,         0);
        check("t6_outputs",    n8,          8);
        check("t6_done_count", dn8,         1);
        check("t6_start_done", dcyc8 - t8,  11);
        check("t6_idle",       busy8,       0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
